// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants.
// Used by uart_rx and intended for reuse by the matching transmitter.
package uart_pkg;

    localparam int unsigned OVERSAMPLE  = 16;
    localparam int unsigned MID_TICK    = 7;
    localparam int unsigned LAST_TICK   = 15;
    localparam int unsigned NB_TICK_CNT = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_t;

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   i_clock   - destination clock
//   i_reset   - synchronous active-high reset, loads RESET_VAL into both flops
//   i_async   - asynchronous input
//   o_sync    - synchronized output (2 clocks of latency)
module uart_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync
);

    logic meta;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            meta   <= RESET_VAL;
            o_sync <= RESET_VAL;
        end else begin
            meta   <= i_async;
            o_sync <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling; samples each bit at its midpoint and
// delivers one NB_DATA-bit word per frame with a one-cycle done strobe.
// Optional even-parity checking is compiled in with UART_RX_PARITY_EN.
// Ports:
//   i_clock        - system clock
//   i_reset        - synchronous active-high reset
//   i_tick         - 16x baud enable pulse
//   i_rx           - asynchronous serial input, idle high
//   o_data         - last received word, held until next frame completes
//   o_rx_done      - one-cycle pulse when o_data updates
//   o_frame_error  - stop bit sampled low for the delivered frame
//   o_parity_error - parity mismatch for the delivered frame (UART_RX_PARITY_EN only)
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned NB_DATA      = 8,
    parameter int unsigned N_STOP_TICKS = 16,
    parameter int unsigned NB_STOP_CNT  = $clog2(N_STOP_TICKS)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
`ifdef UART_RX_PARITY_EN
    output logic               o_parity_error,
`endif
    output logic               o_frame_error
);

    // One counter serves both the 16-tick bit periods and the stop period.
    localparam int unsigned NB_CNT     = (NB_STOP_CNT > NB_TICK_CNT) ? NB_STOP_CNT : NB_TICK_CNT;
    localparam int unsigned NB_BIT_CNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [NB_CNT-1:0]     CNT_MID  = NB_CNT'(MID_TICK);
    localparam logic [NB_CNT-1:0]     CNT_LAST = NB_CNT'(LAST_TICK);
    localparam logic [NB_CNT-1:0]     CNT_STOP = NB_CNT'(N_STOP_TICKS - 1);
    localparam logic [NB_CNT-1:0]     CNT_ONE  = NB_CNT'(1);
    localparam logic [NB_BIT_CNT-1:0] BIT_LAST = NB_BIT_CNT'(NB_DATA - 1);
    localparam logic [NB_BIT_CNT-1:0] BIT_ONE  = NB_BIT_CNT'(1);

    logic                  rx_s;
    uart_state_t           state,     state_next;
    logic [NB_CNT-1:0]     cnt,       cnt_next;
    logic [NB_BIT_CNT-1:0] bit_cnt,   bit_cnt_next;
    logic [NB_DATA-1:0]    shift_reg, shift_next;
    logic [NB_DATA-1:0]    data_next;
    logic                  done_next;
    logic                  ferr_next;
`ifdef UART_RX_PARITY_EN
    logic                  perr_q, perr_q_next;
    logic                  perr_next;
`endif

    uart_sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_async (i_rx),
        .o_sync  (rx_s)
    );

    // State and datapath registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            o_data        <= '0;
            o_rx_done     <= 1'b0;
            o_frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q         <= 1'b0;
            o_parity_error <= 1'b0;
`endif
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            bit_cnt       <= bit_cnt_next;
            shift_reg     <= shift_next;
            o_data        <= data_next;
            o_rx_done     <= done_next;
            o_frame_error <= ferr_next;
`ifdef UART_RX_PARITY_EN
            perr_q         <= perr_q_next;
            o_parity_error <= perr_next;
`endif
        end
    end

    // Next-state and datapath logic; everything advances only on ticks.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_cnt_next = bit_cnt;
        shift_next   = shift_reg;
        data_next    = o_data;
        done_next    = 1'b0;
        ferr_next    = o_frame_error;
`ifdef UART_RX_PARITY_EN
        perr_q_next  = perr_q;
        perr_next    = o_parity_error;
`endif
        if (i_tick) begin
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_next = START;
                        cnt_next   = '0;
                    end
                end
                START: begin
                    if (cnt == CNT_MID) begin
                        // A start bit that has gone high by mid-bit is a glitch.
                        if (!rx_s) begin
                            state_next   = DATA;
                            cnt_next     = '0;
                            bit_cnt_next = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        shift_next = {rx_s, shift_reg[NB_DATA-1:1]};
                        cnt_next   = '0;
                        if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            bit_cnt_next = bit_cnt + BIT_ONE;
                        end
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        // Even parity: total ones over data plus parity must be even.
                        perr_q_next = rx_s ^ (^shift_reg);
                        cnt_next    = '0;
                        state_next  = STOP;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end
`endif
                STOP: begin
                    if (cnt == CNT_STOP) begin
                        data_next  = shift_reg;
                        done_next  = 1'b1;
                        ferr_next  = ~rx_s;
`ifdef UART_RX_PARITY_EN
                        perr_next  = perr_q;
`endif
                        // A low line here is held in BREAK so it cannot retrigger.
                        state_next = rx_s ? IDLE : BREAK;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames from the test plan plus randomized frames,
// checked against a frame-level reference queue built from the bits sent.
module tb_uart_rx;

    logic       i_clock = 1'b0;
    logic       i_reset;
    logic       i_tick;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_error;
    logic       perr_obs;
`ifdef UART_RX_PARITY_EN
    logic       o_parity_error;
    assign perr_obs = o_parity_error;
`else
    assign perr_obs = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    int tick_div = 16;
    int tick_cnt = 0;

    // Observed and expected frames: {parity_error, frame_error, data}.
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    logic       prev_done = 1'b0;
    int         dbl_pulse = 0;

    uart_rx #(
        .NB_DATA      (8),
        .N_STOP_TICKS (16)
    ) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_tick         (i_tick),
        .i_rx           (i_rx),
        .o_data         (o_data),
        .o_rx_done      (o_rx_done),
`ifdef UART_RX_PARITY_EN
        .o_parity_error (o_parity_error),
`endif
        .o_frame_error  (o_frame_error)
    );

    always #5 i_clock = ~i_clock;

    // Free-running tick generator, period tick_div clocks.
    always @(posedge i_clock) begin
        if (tick_cnt >= tick_div - 1) tick_cnt <= 0;
        else                          tick_cnt <= tick_cnt + 1;
    end
    assign i_tick = (tick_cnt == tick_div - 1);

    // Capture every delivered frame and flag any done pulse wider than one cycle.
    always @(negedge i_clock) begin
        if (o_rx_done) got_q.push_back({perr_obs, o_frame_error, o_data});
        if (o_rx_done && prev_done) dbl_pulse <= dbl_pulse + 1;
        prev_done <= o_rx_done;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * tick_div) @(negedge i_clock);
    endtask

    // Drive one full frame; the expected record follows from the bits on the wire.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        logic perr;
        perr = 1'b0;
        i_rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            wait_ticks(16);
        end
`ifdef UART_RX_PARITY_EN
        i_rx = par;
        wait_ticks(16);
        perr = ($countones({b, par}) % 2) != 0;
`endif
        i_rx = stop;
        wait_ticks(16);
        exp_q.push_back({perr, ~stop, b});
    endtask

    function automatic logic even_par(input logic [7:0] b);
        return ($countones(b) % 2) != 0;
    endfunction

    task automatic drain(input string tag);
        logic [9:0] g;
        logic [9:0] e;
        check({tag, ".count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, ".data"}, 32'(g[7:0]), 32'(e[7:0]));
            check({tag, ".ferr"}, 32'(g[8]), 32'(e[8]));
`ifdef UART_RX_PARITY_EN
            check({tag, ".perr"}, 32'(g[9]), 32'(e[9]));
`endif
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".data"}, 32'(o_data), 32'h0);
        check({tag, ".done"}, 32'(o_rx_done), 32'h0);
        check({tag, ".ferr"}, 32'(o_frame_error), 32'h0);
        check({tag, ".perr"}, 32'(perr_obs), 32'h0);
    endtask

    initial begin
        logic [7:0] b;
        logic       stop;
        logic       par;
        logic [7:0] rb;

        i_reset = 1'b1;
        i_rx    = 1'b1;
        repeat (4) @(negedge i_clock);
        check_cleared("reset");
        i_reset = 1'b0;
        wait_ticks(4);

        // Basic frame
        send_frame(8'h55, even_par(8'h55), 1'b1);
        i_rx = 1'b1;
        wait_ticks(20);
        drain("basic");

        // Back-to-back frames, no idle gap
        send_frame(8'hA3, even_par(8'hA3), 1'b1);
        send_frame(8'h0F, even_par(8'h0F), 1'b1);
        i_rx = 1'b1;
        wait_ticks(20);
        drain("b2b");

        // Short glitch must be rejected, then a normal frame still works
        i_rx = 1'b0;
        wait_ticks(4);
        i_rx = 1'b1;
        wait_ticks(30);
        drain("glitch");
        send_frame(8'h5A, even_par(8'h5A), 1'b1);
        i_rx = 1'b1;
        wait_ticks(20);
        drain("post_glitch");

        // Framing error followed by a held-low break
        send_frame(8'hFF, even_par(8'hFF), 1'b0);
        wait_ticks(40);
        i_rx = 1'b1;
        wait_ticks(20);
        drain("break");
        send_frame(8'h81, even_par(8'h81), 1'b1);
        i_rx = 1'b1;
        wait_ticks(20);
        drain("post_break");

        // Reset during data bit 3 of 0xC3
        rb = 8'hC3;
        i_rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
            i_rx = rb[i];
            wait_ticks(16);
        end
        i_rx = rb[3];
        wait_ticks(10);
        i_reset = 1'b1;
        repeat (2) @(negedge i_clock);
        check_cleared("mid_reset");
        i_reset = 1'b0;
        i_rx    = 1'b1;
        wait_ticks(30);
        drain("mid_reset");
        send_frame(8'h3C, even_par(8'h3C), 1'b1);
        i_rx = 1'b1;
        wait_ticks(20);
        drain("post_reset");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b0, 1'b1);
        send_frame(8'h07, 1'b1, 1'b1);
        i_rx = 1'b1;
        wait_ticks(20);
        drain("parity");
`endif

        // Randomized frames, mixed tick rates, random stop levels and gaps
        for (int n = 0; n < 16; n++) begin
            tick_div = ($urandom_range(0, 1) == 0) ? 1 : 16;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            par  = 1'($urandom);
            send_frame(b, par, stop);
            i_rx = 1'b1;
            wait_ticks(stop ? $urandom_range(0, 6) : $urandom_range(3, 6));
        end
        wait_ticks(20);
        drain("random");
        tick_div = 16;

        check("done_width", 32'(dbl_pulse), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
